// File: rtl/frequency_measurement_sequencer_if.sv
// ---------------------------------------------------------------------------
// frequency_measurement_sequencer_if
// Register-write bus between the measurement sequencer and the AXI slave
// register block. The sequencer presents one write at a time and holds it
// until the register block answers with register_ack.
//   register_operation : write code while a write is presented, else 0
//   register_number    : target register, valid with register_operation
//   register_write     : write data, valid with register_operation
//   register_ack       : register block accepted the current write
// ---------------------------------------------------------------------------
interface frequency_measurement_sequencer_if #(
   parameter int DATA_WIDTH = 32
);
   logic [1:0]            register_operation;
   logic [7:0]            register_number;
   logic [DATA_WIDTH-1:0] register_write;
   logic                  register_ack;

   // The sequencer drives the write and listens for the acknowledge
   modport master (
      output register_operation,
      output register_number,
      output register_write,
      input  register_ack
   );

   // The register block consumes the write and answers with the acknowledge
   modport slave (
      input  register_operation,
      input  register_number,
      input  register_write,
      output register_ack
   );
endinterface

// File: rtl/frequency_measurement_sequencer.sv
// ---------------------------------------------------------------------------
// frequency_measurement_sequencer
// Runs one measurement of the pixel frequency analyzers: clears them, enables
// them between start and stop (or an auto-stop limit), waits for the results
// to settle, snapshots every channel and writes the snapshot register by
// register over an acknowledged bus. irq is raised once the results are in.
// Ports:
//   clock, reset      : system clock, synchronous active-high reset
//   start, stop       : single-cycle run request / measurement-end request
//   irq_ack           : single-cycle interrupt acknowledge
//   results           : analyzer outputs, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   regBus            : register write bus (operation/number/write/ack)
//   analyzer_enable   : enable to all analyzers (MEASURE only)
//   analyzer_clear    : clear to all analyzers (CLEAR only)
//   busy              : high outside IDLE and DONE
//   irq               : results readable, held until irq_ack
//   timeout_flag      : last run stopped on the measurement limit
//   write_error       : last run aborted on an acknowledge timeout
// ---------------------------------------------------------------------------
module frequency_measurement_sequencer #(
   parameter int NUMBER_OF_CHANNELS = 6,
   parameter int DATA_WIDTH         = 32,
   parameter int CLEAR_CYCLES       = 4,
   parameter int SETTLE_CYCLES      = 8,
   parameter int MAX_MEASURE_CYCLES = 100000000,
   parameter int ACK_TIMEOUT        = 16,
   parameter int REGISTER_BASE      = 1,
   parameter int WRITE_OPERATION    = 2
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic                                 start,
   input  logic                                 stop,
   input  logic                                 irq_ack,
   input  logic [NUMBER_OF_CHANNELS*DATA_WIDTH-1:0] results,
   frequency_measurement_sequencer_if.master    regBus,
   output logic                                 analyzer_enable,
   output logic                                 analyzer_clear,
   output logic                                 busy,
   output logic                                 irq,
   output logic                                 timeout_flag,
   output logic                                 write_error
);
   localparam int IDX_W = (NUMBER_OF_CHANNELS > 1) ? $clog2(NUMBER_OF_CHANNELS) : 1;

   // register_number is 8-bit; the last channel must still land in range
   if (REGISTER_BASE + NUMBER_OF_CHANNELS - 1 > 255) begin : gRegisterRangeCheck
      $error("REGISTER_BASE + NUMBER_OF_CHANNELS - 1 exceeds 255");
   end

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      MEASURE,
      SETTLE,
      CAPTURE,
      WRITE,
      DONE
   } state_t;

   state_t                state_q, state_d;
   logic [31:0]           count_q, count_d;
   logic [IDX_W-1:0]      index_q, index_d;
   logic                  timeoutFlag_q, timeoutFlag_d;
   logic                  writeError_q, writeError_d;
   logic [DATA_WIDTH-1:0] snapshot_q [NUMBER_OF_CHANNELS];

   // State, counters and sticky flags. The snapshot is only loaded in CAPTURE
   // so that results moving during the writes cannot leak into the data.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         count_q       <= '0;
         index_q       <= '0;
         timeoutFlag_q <= 1'b0;
         writeError_q  <= 1'b0;
         for (int k = 0; k < NUMBER_OF_CHANNELS; k++) begin
            snapshot_q[k] <= '0;
         end
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         index_q       <= index_d;
         timeoutFlag_q <= timeoutFlag_d;
         writeError_q  <= writeError_d;
         if (state_q == CAPTURE) begin
            for (int k = 0; count_q == count_q && k < NUMBER_OF_CHANNELS; k++) begin
               snapshot_q[k] <= results[k*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

   // Next-state logic. One shared counter times CLEAR, MEASURE, SETTLE and
   // the per-write acknowledge wait; it is zeroed on every state change and
   // on every accepted write so each phase starts counting from 0.
   always_comb begin
      state_d       = state_q;
      count_d       = count_q + 32'd1;
      index_d       = index_q;
      timeoutFlag_d = timeoutFlag_q;
      writeError_d  = writeError_q;
      case (state_q)
         IDLE: begin
            count_d = '0;
            if (start) begin
               state_d       = CLEAR;
               timeoutFlag_d = 1'b0;
               writeError_d  = 1'b0;
            end
         end
         CLEAR: begin
            if (count_q == 32'(CLEAR_CYCLES - 1)) begin
               state_d = MEASURE;
               count_d = '0;
            end
         end
         MEASURE: begin
            if (stop) begin
               state_d = SETTLE;
               count_d = '0;
            end else if (count_q == 32'(MAX_MEASURE_CYCLES - 1)) begin
               state_d       = SETTLE;
               count_d       = '0;
               timeoutFlag_d = 1'b1;
            end
         end
         SETTLE: begin
            if (count_q == 32'(SETTLE_CYCLES - 1)) begin
               state_d = CAPTURE;
               count_d = '0;
            end
         end
         CAPTURE: begin
            state_d = WRITE;
            count_d = '0;
            index_d = '0;
         end
         WRITE: begin
            if (regBus.register_ack) begin
               count_d = '0;
               if (index_q == IDX_W'(NUMBER_OF_CHANNELS - 1)) begin
                  state_d = DONE;
               end else begin
                  index_d = index_q + IDX_W'(1);
               end
            end else if (count_q == 32'(ACK_TIMEOUT - 1)) begin
               state_d      = DONE;
               count_d      = '0;
               writeError_d = 1'b1;
            end
         end
         DONE: begin
            count_d = '0;
            if (irq_ack) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            count_d = '0;
         end
      endcase
   end

   // Outputs are a pure function of the registered state, so a write is
   // presented the cycle WRITE is entered and stays stable until acked.
   always_comb begin
      analyzer_clear             = (state_q == CLEAR);
      analyzer_enable            = (state_q == MEASURE);
      busy                       = (state_q != IDLE) && (state_q != DONE);
      irq                        = (state_q == DONE);
      timeout_flag               = timeoutFlag_q;
      write_error                = writeError_q;
      regBus.register_operation  = 2'b00;
      regBus.register_number     = 8'h00;
      regBus.register_write      = '0;
      if (state_q == WRITE) begin
         regBus.register_operation = 2'(WRITE_OPERATION);
         regBus.register_number    = 8'(REGISTER_BASE) + 8'(index_q);
         regBus.register_write     = snapshot_q[index_q];
      end
   end
endmodule

// File: tb/tb_frequency_measurement_sequencer.sv
// ---------------------------------------------------------------------------
// tb_frequency_measurement_sequencer
// Drives whole measurement runs from a table of run descriptions and a few
// hand-written corner sequences. Expected register writes are queued when a
// run is launched and popped as the register bus acknowledges them.
// A second instance with a short measurement limit covers the auto-stop.
// ---------------------------------------------------------------------------
module tb_frequency_measurement_sequencer;
   localparam int NCH = 6;
   localparam int DW  = 32;

   typedef struct {
      logic [7:0]  num;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      int          ackDelay;
      int          dropReg;
      int          measureLen;
      logic [31:0] dataBase;
      int          expWrites;
      int          expIrqDelay;
      logic        expWriteErr;
   } runVec_t;

   logic clock = 1'b0;
   logic reset, start, stop, irq_ack;
   logic [NCH*DW-1:0] results;
   logic analyzer_enable, analyzer_clear, busy, irq, timeout_flag, write_error;
   logic enable2, clear2, busy2, irq2, tflag2, werr2;

   frequency_measurement_sequencer_if #(.DATA_WIDTH(DW)) bus1 ();
   frequency_measurement_sequencer_if #(.DATA_WIDTH(DW)) bus2 ();

   int  checks = 0;
   int  fails = 0;
   int  ackDelay = 0;
   int  dropReg = 0;
   int  writesSeen = 0;
   int  writes2 = 0;
   bit  mon2On = 1'b0;
   wr_t expQ[$];
   wr_t expQ2[$];
   runVec_t runs[3];

   always #5 clock = ~clock;

   assign bus2.register_ack = 1'b1;

   frequency_measurement_sequencer dut (
      .clock(clock), .reset(reset), .start(start), .stop(stop), .irq_ack(irq_ack),
      .results(results), .regBus(bus1),
      .analyzer_enable(analyzer_enable), .analyzer_clear(analyzer_clear),
      .busy(busy), .irq(irq), .timeout_flag(timeout_flag), .write_error(write_error)
   );

   frequency_measurement_sequencer #(.MAX_MEASURE_CYCLES(20)) dutShort (
      .clock(clock), .reset(reset), .start(start), .stop(stop), .irq_ack(irq_ack),
      .results(results), .regBus(bus2),
      .analyzer_enable(enable2), .analyzer_clear(clear2),
      .busy(busy2), .irq(irq2), .timeout_flag(tflag2), .write_error(werr2)
   );

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic setResults(input logic [31:0] base);
      for (int k = 0; k < NCH; k++) begin
         results[k*DW +: DW] = base + 32'(k);
      end
   endtask

   task automatic pushExpected(input logic [31:0] base, input int n);
      wr_t e;
      for (int k = 0; k < n; k++) begin
         e.num  = 8'(1 + k);
         e.data = base + 32'(k);
         expQ.push_back(e);
      end
   endtask

   // Register block model for the main instance: acknowledges after the
   // configured delay (never for dropReg), checks that a held write does not
   // change, and scores every accepted write against the expected queue.
   always @(negedge clock) begin : regBlockModel
      static int  holdCount = 0;
      static bit  holdValid = 1'b0;
      static logic [7:0]  lastNum = '0;
      static logic [31:0] lastData = '0;
      wr_t e;
      if (bus1.register_operation == 2'd2) begin
         if (holdValid && bus1.register_number == lastNum) begin
            holdCount++;
            checkOutput("held write data", bus1.register_write, lastData);
         end else begin
            holdCount = 0;
         end
         holdValid = 1'b1;
         lastNum   = bus1.register_number;
         lastData  = bus1.register_write;
         bus1.register_ack = (int'(bus1.register_number) != dropReg) && (holdCount >= ackDelay);
         if (bus1.register_ack) begin
            writesSeen++;
            if (expQ.size() == 0) begin
               checks++;
               fails++;
               $display("[TB] FAIL unexpected write: got register %0d, want no write", bus1.register_number);
            end else begin
               e = expQ.pop_front();
               checkOutput("write register", bus1.register_number, e.num);
               checkOutput("write data", bus1.register_write, e.data);
            end
         end
      end else begin
         holdValid = 1'b0;
         holdCount = 0;
         bus1.register_ack = 1'b0;
      end
   end

   // Scoreboard for the short-limit instance, only armed for its own test
   always @(negedge clock) begin : shortMonitor
      wr_t e;
      if (mon2On && bus2.register_operation == 2'd2) begin
         writes2++;
         if (expQ2.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL unexpected auto-stop write: got register %0d, want no write", bus2.register_number);
         end else begin
            e = expQ2.pop_front();
            checkOutput("auto-stop write register", bus2.register_number, e.num);
            checkOutput("auto-stop write data", bus2.register_write, e.data);
         end
      end
   end

   task automatic doReset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // One complete run: start, clear, measure, stop, settle, writes, DONE,
   // plus the ignored-start and start-with-irq_ack checks around it.
   task automatic applyStimulus(input runVec_t v);
      int n, en, lat, c;
      ackDelay   = v.ackDelay;
      dropReg    = v.dropReg;
      writesSeen = 0;
      setResults(v.dataBase);
      pushExpected(v.dataBase, v.expWrites);
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (analyzer_clear && n < 20) begin
         n++;
         tick();
      end
      checkOutput("clear cycles", 64'(n), 64'd4);
      checkOutput("enable after clear", analyzer_enable, 1'b1);
      en = 0;
      for (int i = 0; i < v.measureLen; i++) begin
         if (analyzer_enable) en++;
         start = (i == 5);
         stop  = (i == v.measureLen - 1);
         tick();
      end
      start = 1'b0;
      stop  = 1'b0;
      checkOutput("enable cycles", 64'(en), 64'(v.measureLen));
      checkOutput("enable after stop", analyzer_enable, 1'b0);
      lat = 1;
      while (bus1.register_operation != 2'd2 && lat < 100) begin
         tick();
         lat++;
      end
      checkOutput("stop to first write", 64'(lat), 64'd10);
      start   = 1'b1;
      results = ~results;
      tick();
      start = 1'b0;
      c = 1;
      while (!irq && c < 500) begin
         tick();
         c++;
      end
      checkOutput("first write to irq", 64'(c), 64'(v.expIrqDelay));
      checkOutput("timeout_flag", timeout_flag, 1'b0);
      checkOutput("write_error", write_error, v.expWriteErr);
      checkOutput("writes accepted", 64'(writesSeen), 64'(v.expWrites));
      checkOutput("writes outstanding", 64'(expQ.size()), 64'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput("irq after start in DONE", irq, 1'b1);
      checkOutput("busy after start in DONE", busy, 1'b0);
      start   = 1'b1;
      irq_ack = 1'b1;
      tick();
      start   = 1'b0;
      irq_ack = 1'b0;
      checkOutput("irq after irq_ack", irq, 1'b0);
      checkOutput("busy after start+irq_ack", busy, 1'b0);
      tick();
      checkOutput("no run after start+irq_ack", {busy, analyzer_clear}, 2'b00);
      expQ.delete();
   endtask

   initial begin : watchdog
      #500000;
      $display("[TB] FAIL watchdog: got no $finish, want run complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : mainTest
      int n, en;
      runs[0] = '{0, 0, 50, 32'h0000_1000, 6, 6,  1'b0};
      runs[1] = '{3, 0, 10, 32'h0000_2000, 6, 24, 1'b0};
      runs[2] = '{0, 3, 10, 32'h0000_3000, 2, 18, 1'b1};
      reset   = 1'b1;
      start   = 1'b0;
      stop    = 1'b0;
      irq_ack = 1'b0;
      results = '0;
      bus1.register_ack = 1'b0;
      doReset();

      checkOutput("reset outputs",
                  {analyzer_enable, analyzer_clear, busy, irq, timeout_flag, write_error},
                  6'b000000);
      checkOutput("reset operation", bus1.register_operation, 2'd0);
      checkOutput("reset number", bus1.register_number, 8'd0);
      checkOutput("reset data", bus1.register_write, 32'd0);

      stop = 1'b1;
      tick();
      stop = 1'b0;
      checkOutput("stop in IDLE", {busy, analyzer_clear, analyzer_enable}, 3'b000);
      tick();
      checkOutput("stop in IDLE later", busy, 1'b0);

      for (int r = 0; r < 3; r++) begin
         applyStimulus(runs[r]);
      end

      // Auto-stop on the short-limit instance with no stop pulse
      doReset();
      setResults(32'h0000_4000);
      writes2 = 0;
      for (int k = 0; k < NCH; k++) begin
         wr_t e;
         e.num  = 8'(1 + k);
         e.data = 32'h0000_4000 + 32'(k);
         expQ2.push_back(e);
      end
      mon2On = 1'b1;
      start  = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!enable2 && n < 20) begin
         n++;
         tick();
      end
      en = 0;
      while (enable2 && n < 200) begin
         en++;
         n++;
         tick();
      end
      checkOutput("auto-stop enable cycles", 64'(en), 64'd20);
      checkOutput("auto-stop timeout_flag", tflag2, 1'b1);
      n = 0;
      while (!irq2 && n < 200) begin
         n++;
         tick();
      end
      checkOutput("auto-stop irq", irq2, 1'b1);
      checkOutput("auto-stop writes", 64'(writes2), 64'd6);
      checkOutput("auto-stop write_error", werr2, 1'b0);
      checkOutput("auto-stop flag holds in DONE", tflag2, 1'b1);
      mon2On = 1'b0;
      expQ2.delete();
      doReset();

      // Reset while channel 3 (register 4) is presented
      ackDelay   = 3;
      dropReg    = 0;
      writesSeen = 0;
      setResults(32'h0000_5000);
      pushExpected(32'h0000_5000, 6);
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!analyzer_enable && n < 20) begin
         n++;
         tick();
      end
      for (int i = 0; i < 10; i++) begin
         stop = (i == 9);
         tick();
      end
      stop = 1'b0;
      n = 0;
      while (!(bus1.register_operation == 2'd2 && bus1.register_number == 8'd4) && n < 200) begin
         n++;
         tick();
      end
      checkOutput("reached register 4", bus1.register_number, 8'd4);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("outputs after mid-write reset",
                  {analyzer_enable, analyzer_clear, busy, irq, timeout_flag, write_error},
                  6'b000000);
      checkOutput("operation after mid-write reset", bus1.register_operation, 2'd0);
      checkOutput("number after mid-write reset", bus1.register_number, 8'd0);
      checkOutput("data after mid-write reset", bus1.register_write, 32'd0);
      checkOutput("writes before reset", 64'(writesSeen), 64'd3);
      expQ.delete();
      for (int i = 0; i < 5; i++) tick();
      checkOutput("idle after mid-write reset", {busy, bus1.register_operation}, 3'b000);
      applyStimulus(runs[0]);

      $display("[TB] %0d tests run, %0d failed", checks, fails);
      $finish;
   end
endmodule

// File: doc/frequency_measurement_sequencer.md
Name: frequency_measurement_sequencer

Overview:
Controls one measurement run of the pixel frequency analyzers. It clears the analyzers, gates their enable between start and stop, and waits for their outputs to settle. It then snapshots all channel results and writes them one register at a time to the AXI slave register interface, using an acknowledge handshake. It sits between the frame-capture control pulses and the analyzer bank on one side, and the AXI register block on the other, and raises irq when the results are readable.

Parameters:
NUMBER_OF_CHANNELS, 6, number of 32-bit results (pixel/frequency pairs)
DATA_WIDTH, 32, width of each result and of register_write
CLEAR_CYCLES, 4, cycles analyzer_clear is held high at run start (>=1)
SETTLE_CYCLES, 8, wait after measurement ends before snapshot (>=1)
MAX_MEASURE_CYCLES, 100000000, auto-stop limit for MEASURE (1 s at 100 MHz)
ACK_TIMEOUT, 16, cycles to wait for register_ack per write (>=1)
REGISTER_BASE, 1, register_number of channel 0
WRITE_OPERATION, 2, register_operation code for a write (0 = none)

Ports:
clock  in  1  system clock (s00_axi_aclk domain)
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle run request
stop  in  1  single-cycle measurement-end request
irq_ack  in  1  single-cycle interrupt acknowledge from software
results  in  NUMBER_OF_CHANNELS*DATA_WIDTH  analyzer outputs; channel k at bits [k*DATA_WIDTH +: DATA_WIDTH]
register_ack  in  1  AXI register block accepted the current write
analyzer_enable  out  1  enable to all analyzers
analyzer_clear  out  1  clear to all analyzers, active-high
register_operation  out  2  WRITE_OPERATION while a write is presented, else 0
register_number  out  8  target register, valid with register_operation
register_write  out  DATA_WIDTH  write data, valid with register_operation
busy  out  1  high in every state except IDLE and DONE
irq  out  1  results available; level, held until irq_ack
timeout_flag  out  1  last run auto-stopped at MAX_MEASURE_CYCLES
write_error  out  1  last run aborted on an ack timeout

Behaviour:
- One clock, and reset is synchronous and active-high. Reset forces every output to 0, forces the state to IDLE, and zeroes all counters and the snapshot. Reset mid-run aborts the run with no partial writes after that edge.
- States are IDLE, CLEAR, MEASURE, SETTLE, CAPTURE, WRITE, DONE.
- IDLE: on start, go to CLEAR, and clear timeout_flag and write_error. stop and irq_ack are ignored.
- CLEAR: analyzer_clear=1 for exactly CLEAR_CYCLES cycles, then go to MEASURE. start and stop are ignored.
- MEASURE:
  - analyzer_enable=1 in every cycle of this state; it rises the cycle after CLEAR ends.
  - The cycle counter starts at 0 on entry.
  - stop: go to SETTLE.
  - Counter reaching MAX_MEASURE_CYCLES-1 without stop: set timeout_flag and go to SETTLE.
  - stop in that same cycle: go to SETTLE with timeout_flag=0.
  - start is ignored.
- SETTLE: analyzer_enable=0. Wait SETTLE_CYCLES cycles, then go to CAPTURE.
- CAPTURE: a one-cycle state that registers all of results into the snapshot, resets the channel index to 0, and goes to WRITE. Later changes on results do not affect the written data.
- WRITE:
  - Presents register_operation=WRITE_OPERATION, register_number=REGISTER_BASE+index, and register_write=snapshot[index]. All three are stable until acknowledged.
  - On register_ack: if index==NUMBER_OF_CHANNELS-1, go to DONE with outputs 0 on the next cycle. Otherwise increment index; the next write is presented on the next cycle, with no idle gap.
  - register_ack outside WRITE is ignored.
  - No ack for ACK_TIMEOUT cycles: set write_error and go to DONE. The timeout counter restarts on each new index.
- DONE:
  - irq=1 while in DONE.
  - irq_ack: irq=0 and go to IDLE on the next edge.
  - start while irq is high is ignored, including when it coincides with irq_ack. A new run needs start in IDLE.
- timeout_flag and write_error persist until the next accepted start or reset.
- Latency in the ideal case, with stop seen at cycle t and ack always high: register_operation first asserts at t+SETTLE_CYCLES+2, and irq asserts NUMBER_OF_CHANNELS cycles later.
- register_number arithmetic is 8-bit; REGISTER_BASE+NUMBER_OF_CHANNELS-1 must be <=255, and this is checked by a parameter assertion in simulation.

Test Plan:
- Nominal run:
  - Stimulus: reset, start, stop 50 cycles after analyzer_enable rises, results channel k = 0x1000+k, ack tied high.
  - Expected: analyzer_clear high for 4 cycles; then analyzer_enable high for 50 cycles.
  - Expected: six writes, register_number 1..6 with data 0x1000..0x1005 on consecutive cycles, 10 cycles after stop.
  - Expected: irq=1, then irq=0 one cycle after irq_ack.
- Ack backpressure: ack delayed 3 cycles per write; register_number and register_write stay stable for those cycles, and each register is written exactly once.
- Ack timeout: ack never given on channel 2. After 16 cycles, write_error=1 and irq=1. Registers 1 and 2 were acknowledged and register 4 never appears.
- Measurement timeout: MAX_MEASURE_CYCLES=20 and no stop. analyzer_enable is high for exactly 20 cycles, timeout_flag=1, and the writes still occur.
- Ignored events:
  - stop in IDLE does nothing.
  - start during MEASURE or WRITE does nothing.
  - start in DONE does nothing.
  - start and irq_ack in the same cycle go to IDLE with no new run.
  - Changing results after CAPTURE leaves the written data unchanged.
- Reset mid-WRITE: assert reset while channel 3 is presented. The next cycle has all outputs 0 and state IDLE; a following start and stop produce a full six-write run.
